// File: rtl/iter_mul_unit.sv
// Multi-cycle unsigned shift-add multiplier feeding register writeback.
// One multiplier bit per clock; low word to D_out, high word to P_hi.
module iter_mul_unit #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [IDX_W-1:0] DR_in,
    output logic             Busy,
    output logic             Done,
    output logic             LD_REG,
    output logic [IDX_W-1:0] DR,
    output logic [WIDTH-1:0] D_out,
    output logic [WIDTH-1:0] P_hi
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WB
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic             w_last;

    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = r_acc + {1'b0, w_addend};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            LD_REG   <= 1'b0;
            DR       <= '0;
            D_out    <= '0;
            P_hi     <= '0;
        end else begin
            Done   <= 1'b0;
            LD_REG <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_mcand  <= A;
                        r_mplier <= B;
                        DR       <= DR_in;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        Busy     <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Shift {sum, mplier} right; product bits drain into mplier.
                    r_acc    <= {1'b0, w_sum[WIDTH:1]};
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        P_hi    <= w_sum[WIDTH:1];
                        D_out   <= {w_sum[0], r_mplier[WIDTH-1:1]};
                        Done    <= 1'b1;
                        LD_REG  <= 1'b1;
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mul_unit.sv
// Directed self-checking bench for iter_mul_unit.
// Samples on the falling edge; drives inputs on the falling edge.
module tb_iter_mul_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  DR_in;
    logic        Busy;
    logic        Done;
    logic        LD_REG;
    logic [2:0]  DR;
    logic [15:0] D_out;
    logic [15:0] P_hi;

    int n_checks = 0;
    int n_fail   = 0;

    iter_mul_unit #(.WIDTH(16), .IDX_W(3)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .DR_in  (DR_in),
        .Busy   (Busy),
        .Done   (Done),
        .LD_REG (LD_REG),
        .DR     (DR),
        .D_out  (D_out),
        .P_hi   (P_hi)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation; optional second Start pulse at cycle pulse_at.
    task automatic run_op(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] dr,
                          input logic [15:0] exp_lo,
                          input logic [15:0] exp_hi, input int pulse_at);
        int ld_cnt, ld_cyc, busy_cnt, bad_done;
        ld_cnt = 0; ld_cyc = 0; busy_cnt = 0; bad_done = 0;
        @(negedge Clk);
        Start = 1'b1; A = a; B = b; DR_in = dr;
        @(posedge Clk);
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(negedge Clk);
            if (cyc == 1) begin
                Start = 1'b0;
                A = 16'hDEAD; B = 16'hBEEF; DR_in = 3'd5;
            end
            if (pulse_at != 0 && cyc == pulse_at) begin
                Start = 1'b1; A = 16'h0002; B = 16'h0002; DR_in = 3'd1;
            end
            if (pulse_at != 0 && cyc == pulse_at + 1) Start = 1'b0;
            if (Busy) busy_cnt++;
            if (LD_REG) begin
                ld_cnt++;
                ld_cyc = cyc;
                check({tag, "_lo"}, 32'(D_out), 32'(exp_lo));
                check({tag, "_hi"}, 32'(P_hi), 32'(exp_hi));
                check({tag, "_dr"}, 32'(DR), 32'(dr));
            end
            if (Done !== LD_REG) bad_done++;
        end
        check({tag, "_ldcnt"}, 32'(ld_cnt), 32'd1);
        check({tag, "_ldcyc"}, 32'(ld_cyc), 32'd17);
        check({tag, "_busy"}, 32'(busy_cnt), 32'd17);
        check({tag, "_done"}, 32'(bad_done), 32'd0);
        check({tag, "_hold"}, 32'(D_out), 32'(exp_lo));
    endtask

    initial begin
        int ld_cnt, first, last, bad;
        Reset = 1'b1; Start = 1'b0; A = '0; B = '0; DR_in = '0;
        #12;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ld", 32'(LD_REG), 32'd0);
        check("rst_dout", 32'(D_out), 32'd0);
        check("rst_phi", 32'(P_hi), 32'd0);
        check("rst_dr", 32'(DR), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        run_op("m3x5", 16'h0003, 16'h0005, 3'd3, 16'h000F, 16'h0000, 0);
        run_op("mffff", 16'hFFFF, 16'hFFFF, 3'd7, 16'h0001, 16'hFFFE, 0);
        run_op("mzero", 16'h1234, 16'h0000, 3'd2, 16'h0000, 16'h0000, 0);
        run_op("mign", 16'h0010, 16'h0010, 3'd4, 16'h0100, 16'h0000, 5);

        // Reset during RUN iteration 8
        @(negedge Clk);
        Start = 1'b1; A = 16'h00FF; B = 16'h0101; DR_in = 3'd6;
        @(posedge Clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge Clk);
            Start = 1'b0;
        end
        check("pre_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        #1;
        check("ar_busy", 32'(Busy), 32'd0);
        check("ar_dout", 32'(D_out), 32'd0);
        check("ar_phi", 32'(P_hi), 32'd0);
        check("ar_dr", 32'(DR), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        ld_cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge Clk);
            if (LD_REG) ld_cnt++;
        end
        check("ar_nold", 32'(ld_cnt), 32'd0);

        // Start held high: back-to-back every 18 cycles
        @(negedge Clk);
        Start = 1'b1; A = 16'h0002; B = 16'h0003; DR_in = 3'd1;
        @(posedge Clk);
        ld_cnt = 0; first = 0; last = 0; bad = 0;
        for (int cyc = 1; cyc <= 56; cyc++) begin
            @(negedge Clk);
            if (LD_REG) begin
                if (ld_cnt == 0) first = cyc;
                else if (cyc - last != 18) bad++;
                if (D_out !== 16'h0006) bad++;
                last = cyc;
                ld_cnt++;
            end
        end
        Start = 1'b0;
        check("hold_cnt", 32'(ld_cnt), 32'd3);
        check("hold_first", 32'(first), 32'd17);
        check("hold_bad", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
